iob_fifo_sync_ctrl: RTL



---
 rtl/iob_fifo_sync_ctrl_pkg.sv | 16 +
 rtl/iob_fifo_ptr.sv | 34 +++
 rtl/iob_fifo_sync_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/iob_fifo_sync_ctrl_pkg.sv
// Shared types for the synchronous FIFO controller.
// Classifies each cycle by which of push/pop was accepted.
package iob_fifo_sync_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/iob_fifo_ptr.sv
// Wrapping pointer counter with enable, sync clear and async reset.
module iob_fifo_ptr #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         arst_n_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (en_i) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/iob_fifo_sync_ctrl.sv
// Single-clock FIFO controller driving an external two-port RAM.
// Owns pointers, occupancy and flags; data lives in the RAM.
module iob_fifo_sync_ctrl
    import iob_fifo_sync_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              rst_i,
    input  logic              w_en_i,
    input  logic [DATA_W-1:0] w_data_i,
    output logic              w_full_o,
    input  logic              r_en_i,
    output logic [DATA_W-1:0] r_data_o,
    output logic              r_valid_o,
    output logic              r_empty_o,
    output logic [ADDR_W:0]   level_o,
    output logic              ext_mem_clk_o,
    output logic              ext_mem_w_en_o,
    output logic [ADDR_W-1:0] ext_mem_w_addr_o,
    output logic [DATA_W-1:0] ext_mem_w_data_o,
    output logic              ext_mem_r_en_o,
    output logic [ADDR_W-1:0] ext_mem_r_addr_o,
    input  logic [DATA_W-1:0] ext_mem_r_data_i
);

    localparam int LW = ADDR_W + 1;
    localparam logic [LW-1:0] DEPTH = LW'(2 ** ADDR_W);

    logic [LW-1:0]     level_q;
    logic [LW-1:0]     level_d;
    logic              r_valid_q;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] w_ptr;
    logic [ADDR_W-1:0] r_ptr;
    fifo_op_e          op;

    assign w_full_o  = (level_q == DEPTH);
    assign r_empty_o = (level_q == '0);

    // A sync clear or an active async reset blocks any RAM access.
    assign push = w_en_i & ~w_full_o & ~rst_i & arst_n_i;
    assign pop  = r_en_i & ~r_empty_o & ~rst_i & arst_n_i;
    assign op   = fifo_op(push, pop);

    always_comb begin
        level_d = level_q;
        unique case (op)
            OP_PUSH: level_d = level_q + LW'(1);
            OP_POP:  level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            level_q   <= '0;
            r_valid_q <= 1'b0;
        end else if (rst_i) begin
            level_q   <= '0;
            r_valid_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            r_valid_q <= pop;
        end
    end

    iob_fifo_ptr #(.W(ADDR_W)) u_w_ptr (
        .clk_i   (clk_i),
        .arst_n_i(arst_n_i),
        .clr_i   (rst_i),
        .en_i    (push),
        .ptr_o   (w_ptr)
    );

    iob_fifo_ptr #(.W(ADDR_W)) u_r_ptr (
        .clk_i   (clk_i),
        .arst_n_i(arst_n_i),
        .clr_i   (rst_i),
        .en_i    (pop),
        .ptr_o   (r_ptr)
    );

    assign level_o          = level_q;
    assign r_valid_o        = r_valid_q;
    assign r_data_o         = ext_mem_r_data_i;
    assign ext_mem_clk_o    = clk_i;
    assign ext_mem_w_en_o   = push;
    assign ext_mem_w_addr_o = w_ptr;
    assign ext_mem_w_data_o = w_data_i;
    assign ext_mem_r_en_o   = pop;
    assign ext_mem_r_addr_o = r_ptr;

endmodule
